uart_mem_arbiter: RTL
=====================

Name: uart_mem_arbiter

Overview:
- Sits inside min_sopc between the core's instruction-fetch port, its data-memory port and the byte-wide UART link to sim_memory.
- Arbitrates the two requesters onto the single serial memory channel using two-way round-robin.
- Serialises each access into a command frame and deserialises read responses.
- Acknowledges the granted requester; the core stalls on an outstanding request until it receives its ack.

Parameters:
- TIMEOUT, 1024: maximum cycles to wait for each response byte before aborting a read.
- CNT_W, 11: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; level, held until if_ack.
- if_addr  in  32  fetch address.
- mem_req  in  1  data request; level, held until mem_ack.
- mem_we  in  1  1 = write, 0 = read.
- mem_sel  in  4  byte enables; ignored on reads.
- mem_addr  in  32  data address.
- mem_wdata  in  32  write data.
- if_ack  out  1  one-cycle completion pulse to fetch.
- mem_ack  out  1  one-cycle completion pulse to data.
- rdata  out  32  read data; valid on the ack cycle, held until the next read completes.
- err  out  1  pulses with the ack when a read times out.
- busy  out  1  high whenever state is not IDLE.
- tx_data  out  8  byte to UART transmitter.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  transmitter accepts the byte on tx_valid && tx_ready.
- rx_data  in  8  byte from UART receiver.
- rx_valid  in  1  single-cycle strobe per received byte.

Behaviour:
- Reset (rst = 0, asynchronous):
  - State = IDLE.
  - All outputs = 0, rdata = 0.
  - last_grant = IF, so the first conflict goes to MEM.
  - Byte and timeout counters cleared.
- Reset asserted mid-frame aborts immediately; no ack is issued.
- Frame format, multi-byte fields LSB first:
  - Opcode byte: {we, 3'b000, sel}. Fetch always sends 0x0F.
  - Four address bytes.
  - Writes: four data bytes follow. Reads: four response bytes return on rx.
- IDLE:
  - Samples requests only in this state.
  - One requester pending: grant it.
  - Both pending: grant the one not equal to last_grant.
  - On grant: latch addr, we, sel and wdata into internal registers; update last_grant; go to SEND.
  - Requester inputs may change after grant without effect.
- SEND:
  - tx_valid = 1 in the cycle after grant.
  - tx_data is driven from the latched frame at byte index idx.
  - idx advances only on tx_valid && tx_ready; tx_data stays stable while stalled.
  - After byte 4 (read) or byte 8 (write) is accepted:
    - Write: go to DONE.
    - Read: go to RECV with the timeout counter cleared.
- RECV:
  - tx_valid = 0.
  - Each rx_valid stores rx_data into byte lane k (k = 0..3) and clears the timeout counter.
  - Otherwise the counter increments each cycle.
  - After the 4th byte: go to DONE.
  - If the counter reaches TIMEOUT: rdata = 0, err = 1, go to DONE.
- DONE:
  - One cycle only.
  - Pulse the ack of the granted requester (err asserted with it if the read timed out).
  - Return to IDLE.
  - The next grant can occur in the following cycle.
- Latency: minimum read = 1 grant + 5 tx + 4 rx + 1 DONE cycles; write = 1 + 9 + 1 cycles, with tx_ready held high.
- Boundary rules:
  - rx_valid outside RECV is ignored and dropped.
  - A requester dropping req mid-frame does not abort the frame; the ack still pulses.
  - if_ack and mem_ack are never high in the same cycle.
  - rx_valid arriving in the same cycle the counter reaches TIMEOUT: the byte wins and the counter clears.

Decomposition:
- Package riscv_bus_pkg holds:
  - State encoding: IDLE, SEND, RECV, DONE.
  - Grant encoding: GNT_IF, GNT_MEM.
  - Frame length constants: READ_TX_LEN = 5, WRITE_TX_LEN = 9, RESP_LEN = 4.
  - Opcode bit positions.
- One sub-module, rr_arb2: a two-requester round-robin picker holding last_grant.
  - Inputs: clk, rst, req[1:0], update.
  - Output: gnt[1:0].

Test Plan:
- Reset check: assert rst = 0 during activity -> all outputs 0 immediately; after release with no requests, busy stays 0.
- IF read, if_addr = 0x00001004:
  - tx = 0x0F, 0x04, 0x10, 0x00, 0x00.
  - Drive rx = 0x13, 0x00, 0x00, 0x00 -> if_ack pulses once, rdata = 0x00000013, err = 0.
- MEM write, sel = 0011, addr = 0x00000100, wdata = 0xDEADBEEF:
  - tx = 0x83, 0x00, 0x01, 0x00, 0x00, 0xEF, 0xBE, 0xAD, 0xDE.
  - mem_ack pulses 1 cycle after the last byte is accepted; no rx is needed.
- Conflict: if_req and mem_req rise together and are held:
  - MEM is served first, then IF.
  - Re-raise both -> MEM first again.
- Backpressure: drop tx_ready for 3 cycles at byte 2 -> tx_data is held at 0x10 and the frame resumes intact.
- Timeout, TIMEOUT = 16:
  - Send only 2 response bytes, then go silent.
  - 16 cycles later: if_ack = 1, err = 1, rdata = 0.
  - A stray rx byte afterwards is ignored.

Source files
------------

// File: rtl/riscv_bus_pkg.sv
// Shared types and frame constants for the serial memory bus arbiter.
package riscv_bus_pkg;

    // Arbiter/serialiser state encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        RECV = 2'd2,
        DONE = 2'd3
    } state_e;

    // Which requester owns the current frame.
    typedef enum logic [0:0] {
        GNT_IF  = 1'b0,
        GNT_MEM = 1'b1
    } gnt_e;

    // Frame lengths in bytes.
    localparam int unsigned READ_TX_LEN  = 5;
    localparam int unsigned WRITE_TX_LEN = 9;
    localparam int unsigned RESP_LEN     = 4;

    // Opcode byte layout: {we, 3'b000, sel}.
    localparam int unsigned OP_WE_BIT  = 7;
    localparam int unsigned OP_SEL_MSB = 3;
    localparam int unsigned OP_SEL_LSB = 0;

    // Build the opcode byte of a frame.
    function automatic logic [7:0] make_opcode(input logic we, input logic [3:0] sel);
        logic [7:0] op;
        op = 8'h00;
        op[OP_WE_BIT] = we;
        op[OP_SEL_MSB:OP_SEL_LSB] = sel;
        return op;
    endfunction

    // Select byte idx of a frame: opcode, address LSB first, then write data LSB first.
    function automatic logic [7:0] frame_byte(input logic [7:0]  op,
                                              input logic [31:0] addr,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  idx);
        logic [7:0] b;
        case (idx)
            4'd0:    b = op;
            4'd1:    b = addr[7:0];
            4'd2:    b = addr[15:8];
            4'd3:    b = addr[23:16];
            4'd4:    b = addr[31:24];
            4'd5:    b = wdata[7:0];
            4'd6:    b = wdata[15:8];
            4'd7:    b = wdata[23:16];
            4'd8:    b = wdata[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_mem_arbiter_rr_arb2.sv
// Two-requester round-robin picker; req[0] = fetch, req[1] = data.
module rr_arb2
    import riscv_bus_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

    gnt_e last_q;
    gnt_e last_d;

    // Pick a requester; on conflict favour the one not served last.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_q == GNT_IF) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    // Remember the winner only when the grant is actually taken.
    always_comb begin
        last_d = last_q;
        if (update && (gnt != 2'b00)) begin
            last_d = gnt[1] ? GNT_MEM : GNT_IF;
        end else begin
            last_d = last_q;
        end
    end

    // Last-grant register; resets to fetch so the first conflict goes to data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= GNT_IF;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/uart_mem_arbiter.sv
// Arbitrates fetch and data requests onto a byte-wide serial memory link,
// serialising command frames and collecting four-byte read responses.
module uart_mem_arbiter
    import riscv_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CNT_W   = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [3:0]  mem_sel,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        if_ack,
    output logic        mem_ack,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid
);

    localparam logic [3:0]       RD_LAST  = 4'(READ_TX_LEN - 1);
    localparam logic [3:0]       WR_LAST  = 4'(WRITE_TX_LEN - 1);
    localparam logic [1:0]       RX_LAST  = 2'(RESP_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           state_q, state_d;
    gnt_e             gsel_q, gsel_d;
    logic             we_q, we_d;
    logic [7:0]       op_q, op_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       idx_q, idx_d;
    logic [1:0]       k_q, k_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tout_q, tout_d;
    logic [31:0]      rbuf_q, rbuf_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;
    logic             if_ack_q, if_ack_d;
    logic             mem_ack_q, mem_ack_d;
    logic             busy_q, busy_d;
    logic             tx_valid_q, tx_valid_d;
    logic [7:0]       tx_data_q, tx_data_d;

    logic [1:0]       arb_req_s;
    logic [1:0]       arb_gnt_s;
    logic             arb_update_s;
    logic [3:0]       last_idx_s;
    logic             done_entry_s;

    assign arb_req_s    = {mem_req, if_req};
    assign arb_update_s = (state_q == IDLE);

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (arb_req_s),
        .update (arb_update_s),
        .gnt    (arb_gnt_s)
    );

    // Next-state logic: grant, byte serialisation, response collection, timeout.
    always_comb begin
        state_d    = state_q;
        gsel_d     = gsel_q;
        we_d       = we_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        idx_d      = idx_q;
        k_d        = k_q;
        cnt_d      = cnt_q;
        tout_d     = tout_q;
        rbuf_d     = rbuf_q;
        last_idx_s = we_q ? WR_LAST : RD_LAST;

        case (state_q)
            IDLE: begin
                if (arb_gnt_s[1]) begin
                    gsel_d  = GNT_MEM;
                    we_d    = mem_we;
                    op_d    = make_opcode(mem_we, mem_sel);
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                    idx_d   = 4'd0;
                    tout_d  = 1'b0;
                    state_d = SEND;
                end else if (arb_gnt_s[0]) begin
                    gsel_d  = GNT_IF;
                    we_d    = 1'b0;
                    op_d    = make_opcode(1'b0, 4'hF);
                    addr_d  = if_addr;
                    wdata_d = 32'h0000_0000;
                    idx_d   = 4'd0;
                    tout_d  = 1'b0;
                    state_d = SEND;
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                if (tx_valid_q && tx_ready) begin
                    if (idx_q == last_idx_s) begin
                        if (we_q) begin
                            state_d = DONE;
                        end else begin
                            cnt_d   = '0;
                            k_d     = 2'd0;
                            state_d = RECV;
                        end
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            RECV: begin
                // A byte arriving on the timeout cycle wins and restarts the count.
                if (rx_valid) begin
                    case (k_q)
                        2'd0:    rbuf_d[7:0]   = rx_data;
                        2'd1:    rbuf_d[15:8]  = rx_data;
                        2'd2:    rbuf_d[23:16] = rx_data;
                        2'd3:    rbuf_d[31:24] = rx_data;
                        default: rbuf_d        = rbuf_q;
                    endcase
                    cnt_d = '0;
                    k_d   = k_q + 2'd1;
                    if (k_q == RX_LAST) begin
                        state_d = DONE;
                    end else begin
                        state_d = RECV;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = cnt_q + CNT_ONE;
                    tout_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state.
    always_comb begin
        done_entry_s = (state_d == DONE);
        busy_d       = (state_d != IDLE);
        tx_valid_d   = (state_d == SEND);
        if (state_d == SEND) begin
            tx_data_d = frame_byte(op_d, addr_d, wdata_d, idx_d);
        end else begin
            tx_data_d = 8'h00;
        end
        if_ack_d  = done_entry_s && (gsel_d == GNT_IF);
        mem_ack_d = done_entry_s && (gsel_d == GNT_MEM);
        err_d     = done_entry_s && tout_d;
        if (done_entry_s && !we_d) begin
            rdata_d = tout_d ? 32'h0000_0000 : rbuf_d;
        end else begin
            rdata_d = rdata_q;
        end
    end

    // State, frame latch and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            gsel_q     <= GNT_IF;
            we_q       <= 1'b0;
            op_q       <= 8'h00;
            addr_q     <= 32'h0000_0000;
            wdata_q    <= 32'h0000_0000;
            idx_q      <= 4'd0;
            k_q        <= 2'd0;
            cnt_q      <= '0;
            tout_q     <= 1'b0;
            rbuf_q     <= 32'h0000_0000;
            rdata_q    <= 32'h0000_0000;
            err_q      <= 1'b0;
            if_ack_q   <= 1'b0;
            mem_ack_q  <= 1'b0;
            busy_q     <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            gsel_q     <= gsel_d;
            we_q       <= we_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            idx_q      <= idx_d;
            k_q        <= k_d;
            cnt_q      <= cnt_d;
            tout_q     <= tout_d;
            rbuf_q     <= rbuf_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            if_ack_q   <= if_ack_d;
            mem_ack_q  <= mem_ack_d;
            busy_q     <= busy_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign if_ack   = if_ack_q;
    assign mem_ack  = mem_ack_q;
    assign rdata    = rdata_q;
    assign err      = err_q;
    assign busy     = busy_q;
    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;

endmodule
